// File: rtl/brg_vvadd_xcel_ctrl.sv
// Sequencing controller for the VVADD accelerator: issues A/B remote loads,
// pairs the out-of-order returns per slot, emits sums, then sends the signal store.
module brg_vvadd_xcel_ctrl #(
    parameter int data_width_p           = 32,
    parameter int addr_width_p           = 32,
    parameter int len_width_p            = 16,
    parameter int slots_p                = 8,
    parameter int credit_counter_width_p = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              go_v_i,
    input  logic [addr_width_p-1:0]           a_base_i,
    input  logic [addr_width_p-1:0]           b_base_i,
    input  logic [len_width_p-1:0]            len_i,
    input  logic [addr_width_p-1:0]           signal_addr_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              tx_v_o,
    output logic                              tx_fetching_o,
    output logic [addr_width_p-1:0]           tx_addr_o,
    output logic [addr_width_p-1:0]           tx_signal_addr_o,
    output logic [4:0]                        tx_reg_id_o,
    input  logic                              tx_ready_i,
    input  logic [credit_counter_width_p-1:0] tx_credits_i,
    input  logic                              tx_returned_v_i,
    input  logic [data_width_p-1:0]           tx_returned_data_i,
    input  logic [4:0]                        tx_returned_reg_id_i,
    output logic                              res_v_o,
    output logic [len_width_p-1:0]            res_idx_o,
    output logic [data_width_p-1:0]           res_data_o
);

    localparam int SW = $clog2(slots_p);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_SIGNAL = 2'd3;

    logic [1:0]              r_state;
    logic [addr_width_p-1:0] r_aBase;
    logic [addr_width_p-1:0] r_bBase;
    logic [addr_width_p-1:0] r_sigAddr;
    logic [len_width_p-1:0]  r_len;
    logic [len_width_p-1:0]  r_i;
    logic                    r_op;
    logic [len_width_p-1:0]  r_completed;
    logic                    r_done;
    logic                    r_cmplV;
    logic [SW-1:0]           r_cmplSlot;

    logic [slots_p-1:0]      r_occ;
    logic [slots_p-1:0]      r_aOut;
    logic [slots_p-1:0]      r_bOut;
    logic [slots_p-1:0]      r_aArr;
    logic [slots_p-1:0]      r_bArr;

    logic [len_width_p-1:0]  r_idx   [slots_p];
    logic [data_width_p-1:0] r_aData [slots_p];
    logic [data_width_p-1:0] r_bData [slots_p];

    logic [SW-1:0]           w_slot;
    logic                    w_issueV;
    logic                    w_sigV;
    logic                    w_fire;
    logic [SW-1:0]           w_rSlot;
    logic                    w_rOp;
    logic                    w_rInRange;
    logic                    w_rOk;
    logic                    w_rCompletes;
    logic [len_width_p-1:0]  w_iNext;
    logic [len_width_p-1:0]  w_doneCount;

    assign w_slot      = r_i[SW-1:0];
    // B requests always target the slot their A just claimed, so only A waits on occupancy
    assign w_issueV    = (r_state == ST_FETCH) && (tx_credits_i != '0) && (r_op || !r_occ[w_slot]);
    assign w_sigV      = (r_state == ST_SIGNAL);
    assign w_fire      = w_issueV && tx_ready_i;
    assign w_rSlot     = tx_returned_reg_id_i[SW-1:0];
    assign w_rOp       = tx_returned_reg_id_i[4];
    assign w_rInRange  = ({1'b0, tx_returned_reg_id_i[3:0]} < 5'(slots_p));
    assign w_rOk       = tx_returned_v_i && w_rInRange && (w_rOp ? r_bOut[w_rSlot] : r_aOut[w_rSlot]);
    assign w_rCompletes = w_rOk && (w_rOp ? r_aArr[w_rSlot] : r_bArr[w_rSlot]);
    assign w_iNext     = r_i + 1'b1;
    assign w_doneCount = r_completed + len_width_p'(r_cmplV);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_aBase     <= '0;
            r_bBase     <= '0;
            r_sigAddr   <= '0;
            r_len       <= '0;
            r_i         <= '0;
            r_op        <= 1'b0;
            r_completed <= '0;
            r_done      <= 1'b0;
            r_cmplV     <= 1'b0;
            r_cmplSlot  <= '0;
            r_occ       <= '0;
            r_aOut      <= '0;
            r_bOut      <= '0;
            r_aArr      <= '0;
            r_bArr      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_cmplV    <= w_rCompletes;
            r_cmplSlot <= w_rSlot;

            // The completing slot is freed in the same cycle its result is presented
            if (r_cmplV) begin
                r_completed        <= r_completed + 1'b1;
                r_occ[r_cmplSlot]  <= 1'b0;
                r_aArr[r_cmplSlot] <= 1'b0;
                r_bArr[r_cmplSlot] <= 1'b0;
            end

            if (w_rOk) begin
                if (w_rOp) begin
                    r_bOut[w_rSlot] <= 1'b0;
                    r_bArr[w_rSlot] <= 1'b1;
                end else begin
                    r_aOut[w_rSlot] <= 1'b0;
                    r_aArr[w_rSlot] <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (go_v_i) begin
                        r_aBase     <= a_base_i;
                        r_bBase     <= b_base_i;
                        r_sigAddr   <= signal_addr_i;
                        r_len       <= len_i;
                        r_i         <= '0;
                        r_op        <= 1'b0;
                        r_completed <= '0;
                        r_state     <= (len_i != '0) ? ST_FETCH : ST_SIGNAL;
                    end
                end
                ST_FETCH: begin
                    if (w_fire) begin
                        if (!r_op) begin
                            r_occ[w_slot]  <= 1'b1;
                            r_aOut[w_slot] <= 1'b1;
                            r_op           <= 1'b1;
                        end else begin
                            r_bOut[w_slot] <= 1'b1;
                            r_op           <= 1'b0;
                            r_i            <= w_iNext;
                            if (w_iNext == r_len)
                                r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_doneCount == r_len)
                        r_state <= ST_SIGNAL;
                end
                default: begin
                    if (tx_ready_i) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fire && !r_op)
            r_idx[w_slot] <= r_i;
        if (w_rOk) begin
            if (w_rOp)
                r_bData[w_rSlot] <= tx_returned_data_i;
            else
                r_aData[w_rSlot] <= tx_returned_data_i;
        end
    end

    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = r_done;
    assign tx_v_o           = w_issueV || w_sigV;
    assign tx_fetching_o    = (r_state != ST_SIGNAL);
    assign tx_addr_o        = (r_op ? r_bBase : r_aBase) + addr_width_p'(r_i);
    assign tx_signal_addr_o = r_sigAddr;
    assign tx_reg_id_o      = w_sigV ? 5'd0 : {r_op, 4'(w_slot)};
    assign res_v_o          = r_cmplV;
    assign res_idx_o        = r_idx[r_cmplSlot];
    assign res_data_o       = r_aData[r_cmplSlot] + r_bData[r_cmplSlot];

`ifndef SYNTHESIS
    // Returns for tags that are not outstanding are dropped; flag them in simulation
    always @(posedge clk_i) begin
        if (!reset_i && tx_returned_v_i)
            assert (w_rOk);
    end
`endif

endmodule

// File: tb/tb_brg_vvadd_xcel_ctrl.sv
// Scoreboard bench for brg_vvadd_xcel_ctrl: directed runs push expected requests/results,
// a monitor pops and compares them as the DUT presents them.
module tb_brg_vvadd_xcel_ctrl;

    logic        clock;
    logic        reset;
    logic        go_v_i;
    logic [31:0] a_base_i;
    logic [31:0] b_base_i;
    logic [15:0] len_i;
    logic [31:0] signal_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        tx_v_o;
    logic        tx_fetching_o;
    logic [31:0] tx_addr_o;
    logic [31:0] tx_signal_addr_o;
    logic [4:0]  tx_reg_id_o;
    logic        tx_ready_i;
    logic [3:0]  tx_credits_i;
    logic        tx_returned_v_i;
    logic [31:0] tx_returned_data_i;
    logic [4:0]  tx_returned_reg_id_i;
    logic        res_v_o;
    logic [15:0] res_idx_o;
    logic [31:0] res_data_o;

    typedef struct {
        bit          fetching;
        logic [31:0] addr;
        logic [4:0]  rid;
    } reqT;

    typedef struct {
        logic [4:0]  rid;
        logic [31:0] data;
    } retT;

    typedef struct {
        logic [15:0] idx;
        logic [31:0] data;
    } resT;

    reqT reqQ[$];
    retT retQ[$];
    retT manualQ[$];
    resT resQ[$];
    int  doneExp;
    bit  autoReturn;
    int  compared;
    int  mismatched;

    brg_vvadd_xcel_ctrl dut (
        .clk_i                (clock),
        .reset_i              (reset),
        .go_v_i               (go_v_i),
        .a_base_i             (a_base_i),
        .b_base_i             (b_base_i),
        .len_i                (len_i),
        .signal_addr_i        (signal_addr_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .tx_v_o               (tx_v_o),
        .tx_fetching_o        (tx_fetching_o),
        .tx_addr_o            (tx_addr_o),
        .tx_signal_addr_o     (tx_signal_addr_o),
        .tx_reg_id_o          (tx_reg_id_o),
        .tx_ready_i           (tx_ready_i),
        .tx_credits_i         (tx_credits_i),
        .tx_returned_v_i      (tx_returned_v_i),
        .tx_returned_data_i   (tx_returned_data_i),
        .tx_returned_reg_id_i (tx_returned_reg_id_i),
        .res_v_o              (res_v_o),
        .res_idx_o            (res_idx_o),
        .res_data_o           (res_data_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got unexpected event, want none", name);
    endtask

    // Memory image seen through the TX block
    function automatic logic [31:0] memData(input logic [31:0] addr);
        if (addr == 32'hFFFF_FFFF)      return 32'hFFFF_FFFF;
        else if (addr < 32'h100)        return 32'd5;
        else if (addr < 32'h200)        return addr - 32'h100;
        else if (addr < 32'h300)        return 32'd10 * (addr - 32'h200);
        else                            return 32'd2;
    endfunction

    // Monitor: compares every accepted request, result and done pulse against the queues
    always @(negedge clock) begin
        if (!reset) begin
            if (tx_v_o && tx_ready_i) begin
                if (reqQ.size() == 0) begin
                    failNote("unexpected_req");
                end else begin
                    reqT e;
                    e = reqQ.pop_front();
                    checkOutput("req_fetching", tx_fetching_o, e.fetching);
                    if (e.fetching) begin
                        checkOutput("req_addr", tx_addr_o, e.addr);
                        checkOutput("req_reg_id", tx_reg_id_o, e.rid);
                        retQ.push_back('{rid: tx_reg_id_o, data: memData(tx_addr_o)});
                    end else begin
                        checkOutput("sig_addr", tx_signal_addr_o, e.addr);
                        checkOutput("sig_reg_id", tx_reg_id_o, 5'd0);
                        checkOutput("sig_after_results", resQ.size(), 0);
                    end
                end
            end
            if (res_v_o) begin
                if (resQ.size() == 0) begin
                    failNote("unexpected_res");
                end else begin
                    resT r;
                    r = resQ.pop_front();
                    checkOutput("res_idx", res_idx_o, r.idx);
                    checkOutput("res_data", res_data_o, r.data);
                end
            end
            if (done_o) begin
                checkOutput("done_expected", doneExp > 0, 1'b1);
                if (doneExp > 0) doneExp--;
            end
        end
    end

    // Return driver: manual returns take priority, otherwise in-order auto returns
    always @(posedge clock) begin
        #1;
        if (manualQ.size() != 0) begin
            retT m;
            m = manualQ.pop_front();
            tx_returned_v_i      = 1'b1;
            tx_returned_reg_id_i = m.rid;
            tx_returned_data_i   = m.data;
        end else if (autoReturn && retQ.size() != 0) begin
            retT m;
            m = retQ.pop_front();
            tx_returned_v_i      = 1'b1;
            tx_returned_reg_id_i = m.rid;
            tx_returned_data_i   = m.data;
        end else begin
            tx_returned_v_i      = 1'b0;
            tx_returned_reg_id_i = 5'd0;
            tx_returned_data_i   = 32'd0;
        end
    end

    task automatic pushRequests(input logic [31:0] aBase, input logic [31:0] bBase,
                                input int len, input logic [31:0] sig);
        for (int i = 0; i < len; i++) begin
            reqQ.push_back('{fetching: 1'b1, addr: aBase + 32'(i), rid: {1'b0, 4'(i % 8)}});
            reqQ.push_back('{fetching: 1'b1, addr: bBase + 32'(i), rid: {1'b1, 4'(i % 8)}});
        end
        reqQ.push_back('{fetching: 1'b0, addr: sig, rid: 5'd0});
        doneExp++;
    endtask

    task automatic pushStdResults(input int len);
        for (int i = 0; i < len; i++)
            resQ.push_back('{idx: 16'(i), data: 32'(11 * i)});
    endtask

    task automatic applyStimulus(input logic [31:0] aBase, input logic [31:0] bBase,
                                 input logic [15:0] len, input logic [31:0] sig,
                                 input logic expectV);
        @(posedge clock); #1;
        a_base_i      = aBase;
        b_base_i      = bBase;
        len_i         = len;
        signal_addr_i = sig;
        go_v_i        = 1'b1;
        @(posedge clock); #1;
        go_v_i = 1'b0;
        @(negedge clock);
        checkOutput("first_tx_v", tx_v_o, expectV);
        checkOutput("busy_after_go", busy_o, 1'b1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (busy_o) begin
            $display("[TB] FAIL wait_idle: got busy after %0d cycles, want idle", budget);
            compared++;
            mismatched++;
        end
    endtask

    task automatic waitAccepted(input int cnt, input int budget);
        int n = 0;
        while (retQ.size() < cnt && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("accepted_count", retQ.size() >= cnt, 1'b1);
    endtask

    task automatic finishTest(input string name);
        repeat (3) @(negedge clock);
        checkOutput({name, "_req_left"}, reqQ.size(), 0);
        checkOutput({name, "_res_left"}, resQ.size(), 0);
        checkOutput({name, "_done_left"}, doneExp, 0);
        checkOutput({name, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        bit          prevHold;
        logic [31:0] prevAddr;
        logic [4:0]  prevRid;
        int          n;

        compared      = 0;
        mismatched    = 0;
        doneExp       = 0;
        autoReturn    = 1'b0;
        reset         = 1'b1;
        go_v_i        = 1'b0;
        a_base_i      = '0;
        b_base_i      = '0;
        len_i         = '0;
        signal_addr_i = '0;
        tx_ready_i    = 1'b1;
        tx_credits_i  = 4'd8;

        repeat (3) @(negedge clock);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_tx_v", tx_v_o, 1'b0);
        checkOutput("rst_res_v", res_v_o, 1'b0);
        checkOutput("rst_fetching", tx_fetching_o, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] basic run");
        autoReturn = 1'b1;
        pushRequests(32'h100, 32'h200, 4, 32'h4000);
        pushStdResults(4);
        applyStimulus(32'h100, 32'h200, 16'd4, 32'h4000, 1'b1);
        waitIdle(300);
        finishTest("basic");

        $display("[TB] out-of-order returns");
        autoReturn = 1'b0;
        pushRequests(32'h100, 32'h200, 3, 32'h4100);
        resQ.push_back('{idx: 16'd2, data: 32'd22});
        resQ.push_back('{idx: 16'd1, data: 32'd11});
        resQ.push_back('{idx: 16'd0, data: 32'd0});
        applyStimulus(32'h100, 32'h200, 16'd3, 32'h4100, 1'b1);
        waitAccepted(6, 50);
        retQ.delete();
        @(negedge clock);
        checkOutput("drain_no_tx", tx_v_o, 1'b0);
        manualQ.push_back('{rid: 5'h12, data: 32'd20});
        manualQ.push_back('{rid: 5'h11, data: 32'd10});
        manualQ.push_back('{rid: 5'h10, data: 32'd0});
        manualQ.push_back('{rid: 5'h02, data: 32'd2});
        manualQ.push_back('{rid: 5'h01, data: 32'd1});
        manualQ.push_back('{rid: 5'h00, data: 32'd0});
        waitIdle(300);
        finishTest("ooo");

        $display("[TB] credit and ready stall");
        autoReturn   = 1'b1;
        tx_credits_i = 4'd0;
        pushRequests(32'h100, 32'h200, 2, 32'h4200);
        pushStdResults(2);
        applyStimulus(32'h100, 32'h200, 16'd2, 32'h4200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("no_credit_tx_v", tx_v_o, 1'b0);
        end
        @(posedge clock); #1;
        tx_credits_i = 4'd8;
        tx_ready_i   = 1'b0;
        prevHold     = 1'b0;
        prevAddr     = '0;
        prevRid      = '0;
        n            = 0;
        while (busy_o && n < 200) begin
            @(negedge clock);
            if (prevHold && tx_fetching_o) begin
                checkOutput("stall_addr", tx_addr_o, prevAddr);
                checkOutput("stall_reg_id", tx_reg_id_o, prevRid);
            end
            prevHold = tx_v_o && !tx_ready_i && tx_fetching_o;
            prevAddr = tx_addr_o;
            prevRid  = tx_reg_id_o;
            @(posedge clock); #1;
            tx_ready_i = ~tx_ready_i;
            n++;
        end
        tx_ready_i = 1'b1;
        waitIdle(300);
        finishTest("stall");

        $display("[TB] slot exhaustion");
        autoReturn = 1'b0;
        pushRequests(32'h100, 32'h200, 20, 32'h4300);
        pushStdResults(20);
        applyStimulus(32'h100, 32'h200, 16'd20, 32'h4300, 1'b1);
        waitAccepted(16, 100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("full_tx_v", tx_v_o, 1'b0);
        end
        autoReturn = 1'b1;
        waitIdle(1000);
        finishTest("slots");

        $display("[TB] zero length");
        pushRequests(32'h100, 32'h200, 0, 32'h5000);
        applyStimulus(32'h100, 32'h200, 16'd0, 32'h5000, 1'b1);
        waitIdle(50);
        finishTest("zero");

        $display("[TB] wrap");
        reqQ.push_back('{fetching: 1'b1, addr: 32'hFFFF_FFFF, rid: 5'h00});
        reqQ.push_back('{fetching: 1'b1, addr: 32'h300,       rid: 5'h10});
        reqQ.push_back('{fetching: 1'b1, addr: 32'h0,         rid: 5'h01});
        reqQ.push_back('{fetching: 1'b1, addr: 32'h301,       rid: 5'h11});
        reqQ.push_back('{fetching: 1'b0, addr: 32'h5100,      rid: 5'h00});
        doneExp++;
        resQ.push_back('{idx: 16'd0, data: 32'd1});
        resQ.push_back('{idx: 16'd1, data: 32'd7});
        applyStimulus(32'hFFFF_FFFF, 32'h300, 16'd2, 32'h5100, 1'b1);
        waitIdle(300);
        finishTest("wrap");

        $display("[TB] ignored go and reset mid-run");
        autoReturn = 1'b0;
        pushRequests(32'h100, 32'h200, 6, 32'h5200);
        applyStimulus(32'h100, 32'h200, 16'd6, 32'h5200, 1'b1);
        waitAccepted(2, 50);
        @(posedge clock); #1;
        a_base_i = 32'h900;
        len_i    = 16'd0;
        go_v_i   = 1'b1;
        @(posedge clock); #1;
        go_v_i = 1'b0;
        waitAccepted(5, 50);
        checkOutput("busy_ignored_go", busy_o, 1'b1);
        checkOutput("fetch_ignored_go", tx_fetching_o, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        #2;
        checkOutput("mid_rst_tx_v", tx_v_o, 1'b0);
        checkOutput("mid_rst_busy", busy_o, 1'b0);
        checkOutput("mid_rst_res_v", res_v_o, 1'b0);
        checkOutput("mid_rst_done", done_o, 1'b0);
        reqQ.delete();
        retQ.delete();
        resQ.delete();
        doneExp = 0;
        @(posedge clock); #1;
        reset      = 1'b0;
        autoReturn = 1'b1;
        pushRequests(32'h100, 32'h200, 4, 32'h6000);
        pushStdResults(4);
        applyStimulus(32'h100, 32'h200, 16'd4, 32'h6000, 1'b1);
        waitIdle(300);
        finishTest("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/brg_vvadd_xcel_ctrl.md
Name: brg_vvadd_xcel_ctrl

Overview:
- Sequencing controller for the VVADD accelerator's master-side network TX block.
- On a start command it issues remote-load requests for A[i] and B[i] for i = 0..len-1 and tags each with a reg_id.
- It pairs the returned operands out of order, writes each sum A[i]+B[i] to the local result port, and finally issues the completion signal store.
- It sits between the accelerator's CSR/start logic and the TX block's xcel-side interface.

Parameters:
- data_width_p, 32, operand/result width.
- addr_width_p, 32, word-address width of the request address.
- len_width_p, 16, width of the element count.
- slots_p, 8, number of in-flight A/B pairs; power of 2, at most 16.
- credit_counter_width_p, 4, width of the credit count from TX.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- go_v_i  in  1  start pulse; sampled only in IDLE.
- a_base_i  in  addr_width_p  word address of A[0].
- b_base_i  in  addr_width_p  word address of B[0].
- len_i  in  len_width_p  element count.
- signal_addr_i  in  addr_width_p  completion-store address, latched at go.
- busy_o  out  1  high when state != IDLE.
- done_o  out  1  one-cycle pulse when the signal store is accepted.
- tx_v_o  out  1  request valid.
- tx_fetching_o  out  1  1 = load, 0 = signal store.
- tx_addr_o  out  addr_width_p  load address.
- tx_signal_addr_o  out  addr_width_p  latched signal_addr_i.
- tx_reg_id_o  out  5  request tag {operand, slot}.
- tx_ready_i  in  1  TX accepts the request this cycle.
- tx_credits_i  in  credit_counter_width_p  remaining out-credits.
- tx_returned_v_i  in  1  load return valid; always consumed.
- tx_returned_data_i  in  data_width_p  returned data.
- tx_returned_reg_id_i  in  5  tag of the return.
- res_v_o  out  1  result write valid; always accepted.
- res_idx_o  out  len_width_p  element index i.
- res_data_o  out  data_width_p  A[i]+B[i].

Behaviour:
- **Reset values** (asynchronous reset_i): state = IDLE; all slot valid bits = 0; counters = 0; busy_o, done_o, tx_v_o, res_v_o = 0; tx_fetching_o = 1.
- **States:** IDLE, FETCH, DRAIN, SIGNAL.
- **IDLE:**
  - On go_v_i, latch the bases, len_i and signal_addr_i; clear issue index i and completed count.
  - Next state is FETCH if len_i != 0, otherwise SIGNAL.
  - go_v_i outside IDLE is ignored.
- **Operand phase:** a flag op toggles A(0) then B(1) per element.
- **FETCH issue:**
  - Slot s = i mod slots_p.
  - tx_v_o = 1 iff tx_credits_i != 0 and slot s is not occupied (a B-phase request always targets an occupied slot it owns).
  - tx_v_o never depends on tx_ready_i.
  - tx_fetching_o = 1; tx_addr_o = (op ? b_base : a_base) + i, modulo 2^addr_width_p; tx_reg_id_o = {op, s} zero-extended to 5 bits.
- **FETCH handshake:**
  - On tx_v_o & tx_ready_i: if op = A, mark slot s occupied, record idx = i, and set op = B. Otherwise set op = A and i++.
  - When i reaches len after a B is accepted, go to DRAIN.
- **Return:** on tx_returned_v_i, reg_id[4] selects the A or B field of slot reg_id[3:0]; store the data and set the matching arrived bit.
  - Returns arrive in any order and at most one per cycle.
- **Completion:**
  - When a return makes both arrived bits true, next cycle drive res_v_o = 1, res_idx_o = slot idx, res_data_o = A+B truncated to data_width_p (wrap, no saturation).
  - In that same cycle the slot is freed and completed++.
  - A return and a completion on different slots in the same cycle are both honoured.
- **DRAIN:** when completed == len (including the completion in flight), go to SIGNAL.
- **SIGNAL:**
  - tx_v_o = 1, tx_fetching_o = 0, tx_reg_id_o = 0.
  - On tx_ready_i: done_o = 1 for 1 cycle (registered, cycle after acceptance), then IDLE.
  - The signal store is not gated by credits (TX/endpoint enforces them).
- **Stalls:** in FETCH, credits = 0 or tx_ready_i = 0 holds all tx_* outputs stable.
- **Latency:** go at cycle 0 → first tx_v_o at cycle 1 (if credits are available).
- **Error case:** a return on a slot/operand not outstanding is a protocol error; assertion under translate_off, and the state is unchanged.
- **Reset mid-operation:** all state is discarded; late returns after reset are ignored via the same error check.

Test Plan:
- **Basic run:** len=4, a_base=0x100, b_base=0x200, credits=8, ready=1, in-order returns A=i, B=10*i. Expect: loads 0x100,0x200,0x101,0x201,… with reg_ids 0x00,0x10,0x01,0x11,…; res (0,0),(1,11),(2,22),(3,33); then one store to signal_addr with fetching=0; done_o pulse; busy_o low.
- **Out-of-order returns:** len=3, all B returned before all A, reversed. Expect every res_idx 0..2 exactly once with correct sums; SIGNAL only after the third result.
- **Credit and ready stall:** credits=0 for 5 cycles, then tx_ready_i toggling. Expect tx_v_o low while credits=0; address/tag stable while ready=0; no duplicate or skipped requests.
- **Slot exhaustion:** len=20, slots_p=8, no returns until 16 loads are issued. Expect tx_v_o=0 at the 17th request until slot 0 completes, then issue resumes at index 8 reusing slot 0.
- **Zero length and wrap:** len=0 → signal store next cycle, no loads, no res_v_o. Separately, A=0xFFFF_FFFF, B=2 → res_data=1; a_base=0xFFFF_FFFF, i=1 → address 0.
- **Reset mid-run and ignored go:** assert reset_i during FETCH → all outputs 0 immediately; a new go then completes normally. go_v_i asserted while busy → ignored.
